// File: rtl/led_flow_pkg.sv
// led_flow_pkg: shared state and mode encodings for the LED flow sequencer.
package led_flow_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        PAUSE = 2'd3
    } state_t;

    localparam logic [1:0] MODE_LEFT   = 2'b00;
    localparam logic [1:0] MODE_RIGHT  = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_BLINK  = 2'b11;

endpackage

// File: rtl/led_flow_ctrl_tick.sv
// tick_gen: shared step prescaler; counts 0..CNT_MAX while en, clr wins over en.
module tick_gen #(
    parameter int              CNT_W   = 25,
    parameter logic [CNT_W-1:0] CNT_MAX = 25'd24_999_999
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_MAX);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= tick ? '0 : cnt + CNT_W'(1);
    end

endmodule

// File: rtl/led_flow_ctrl.sv
// led_flow_ctrl: start/stop sequencer driving running-light, bounce or blink patterns.
// Define LED_FLOW_PAUSE_EN to add the level-sensitive pause input and PAUSE state.
module led_flow_ctrl
    import led_flow_pkg::*;
#(
    parameter int               LED_NUM = 4,
    parameter int               CNT_W   = 25,
    parameter logic [CNT_W-1:0] CNT_MAX = 25'd24_999_999
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         mode,
`ifdef LED_FLOW_PAUSE_EN
    input  logic               pause,
`endif
    output logic               busy,
    output logic [LED_NUM-1:0] led_out,
    output logic               step_done
);

    localparam logic [LED_NUM-1:0] LSB_ON = LED_NUM'(1);
    localparam logic [LED_NUM-1:0] MSB_ON = LSB_ON << (LED_NUM - 1);

    state_t             state, state_nx;
    logic [1:0]         mode_q;
    logic               dir, dir_step;
    logic [LED_NUM-1:0] led_step, led_init;
    logic               hold, active, run_en, adv, tick;

`ifdef LED_FLOW_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    // PAUSE with pause released counts like RUN so resume costs no extra cycle
    assign active = (state == RUN) || (state == PAUSE);
    assign run_en = active && !hold && !stop;
    assign adv    = run_en && tick;
    assign busy   = (state != IDLE);

    tick_gen #(.CNT_W(CNT_W), .CNT_MAX(CNT_MAX)) u_tick (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .en      (run_en),
        .clr     ((state_nx == IDLE) || (state == LOAD)),
        .tick    (tick)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (start && !stop) ? LOAD : IDLE;
            LOAD:    state_nx = stop ? IDLE : RUN;
            RUN:     state_nx = stop ? IDLE : hold ? PAUSE : RUN;
            PAUSE:   state_nx = stop ? IDLE : hold ? PAUSE : RUN;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        led_init = (mode_q == MODE_RIGHT) ? MSB_ON : (mode_q == MODE_BLINK) ? '0 : LSB_ON;
    end

    // bounce flips direction on the step that lands on an end bit
    always_comb begin
        led_step = led_out;
        dir_step = dir;
        case (mode_q)
            MODE_LEFT:  led_step = {led_out[LED_NUM-2:0], led_out[LED_NUM-1]};
            MODE_RIGHT: led_step = {led_out[0], led_out[LED_NUM-1:1]};
            MODE_BOUNCE: begin
                led_step = dir ? (led_out >> 1) : (led_out << 1);
                dir_step = dir ? !led_step[0] : led_step[LED_NUM-1];
            end
            default:    led_step = ~led_out;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= IDLE;
            mode_q    <= MODE_LEFT;
            dir       <= 1'b0;
            led_out   <= '0;
            step_done <= 1'b0;
        end else begin
            state     <= state_nx;
            mode_q    <= (state == IDLE && start && !stop) ? mode : mode_q;
            dir       <= (state == LOAD) ? 1'b0 : adv ? dir_step : dir;
            led_out   <= (state_nx == IDLE) ? '0 : (state == LOAD) ? led_init : adv ? led_step : led_out;
            step_done <= adv;
        end
    end

endmodule

// File: tb/tb_led_flow_ctrl.sv
// tb_led_flow_ctrl: directed checks of led_flow_ctrl with LED_NUM=4, CNT_MAX=3.
module tb_led_flow_ctrl;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       start   = 1'b0;
    logic       stop    = 1'b0;
    logic [1:0] mode    = 2'b00;
    logic       busy;
    logic [3:0] led_out;
    logic       step_done;
`ifdef LED_FLOW_PAUSE_EN
    logic       pause   = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_q[$];

    led_flow_ctrl #(.LED_NUM(4), .CNT_W(2), .CNT_MAX(2'd3)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
`ifdef LED_FLOW_PAUSE_EN
        .pause     (pause),
`endif
        .busy      (busy),
        .led_out   (led_out),
        .step_done (step_done)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic cyc();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, want, $time);
        end
    endtask

    // start in cycle 0, then compare led_out/step_done each cycle against exp_q (one entry per 4 cycles)
    task automatic run_seq(input logic [1:0] m, input bit inject);
        int last;
        start = 1'b1;
        mode  = m;
        cyc();
        start = 1'b0;
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_led", 32'(led_out), 32'd0);
        cyc();
        last = 2 + 4 * (exp_q.size() - 1);
        for (int c = 2; c <= last; c++) begin
            mode  = 2'($urandom);
            start = inject && (c == 7);
            chk("led", 32'(led_out), 32'(exp_q[(c - 2) / 4]));
            chk("step", 32'(step_done), 32'(c > 2 && (c - 2) % 4 == 0));
            chk("busy", 32'(busy), 32'd1);
            cyc();
        end
        start = 1'b0;
        stop  = 1'b1;
        cyc();
        stop  = 1'b0;
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_led", 32'(led_out), 32'd0);
    endtask

    initial begin
        #12;
        chk("rst_led", 32'(led_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_step", 32'(step_done), 32'd0);
        sys_rst = 1'b0;
        repeat (3) cyc();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_led", 32'(led_out), 32'd0);

        exp_q = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
        run_seq(2'b00, 1'b0);
        exp_q = '{4'h8, 4'h4, 4'h2, 4'h1, 4'h8};
        run_seq(2'b01, 1'b0);
        exp_q = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};
        run_seq(2'b10, 1'b0);
        exp_q = '{4'h0, 4'hf, 4'h0, 4'hf, 4'h0};
        run_seq(2'b11, 1'b1);

        // stop in the tick cycle (cycle 5) suppresses the step
        start = 1'b1;
        mode  = 2'b00;
        cyc();
        start = 1'b0;
        repeat (4) cyc();
        chk("pre_stop_led", 32'(led_out), 32'h1);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("col_busy", 32'(busy), 32'd0);
        chk("col_led", 32'(led_out), 32'd0);
        chk("col_step", 32'(step_done), 32'd0);

        // start and stop together in IDLE
        start = 1'b1;
        stop  = 1'b1;
        cyc();
        start = 1'b0;
        stop  = 1'b0;
        chk("ss_busy", 32'(busy), 32'd0);
        cyc();
        chk("ss_busy2", 32'(busy), 32'd0);
        chk("ss_led", 32'(led_out), 32'd0);

        // asynchronous reset right after a step
        start = 1'b1;
        mode  = 2'b00;
        cyc();
        start = 1'b0;
        repeat (5) cyc();
        chk("prerst_led", 32'(led_out), 32'h2);
        chk("prerst_step", 32'(step_done), 32'd1);
        #2 sys_rst = 1'b1;
        #1;
        chk("arst_led", 32'(led_out), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_step", 32'(step_done), 32'd0);
        repeat (2) cyc();
        sys_rst = 1'b0;
        repeat (4) cyc();
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_led", 32'(led_out), 32'd0);

`ifdef LED_FLOW_PAUSE_EN
        // pause high in cycles 3..7 pushes the first step from cycle 6 to 11
        start = 1'b1;
        mode  = 2'b00;
        cyc();
        start = 1'b0;
        cyc();
        for (int c = 2; c <= 11; c++) begin
            pause = (c >= 3 && c <= 7);
            chk("p_led", 32'(led_out), (c == 11) ? 32'h2 : 32'h1);
            chk("p_step", 32'(step_done), 32'(c == 11));
            chk("p_busy", 32'(busy), 32'd1);
            cyc();
        end
        pause = 1'b0;
        stop  = 1'b1;
        cyc();
        stop  = 1'b0;
        chk("p_stop_busy", 32'(busy), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_flow_ctrl.md
# led_flow_ctrl

Sequencer for a bank of LEDs driven from one shared tick counter. Accepts start/stop commands, latches a display mode, and advances a running-light, bounce or blink pattern once per tick period. It sits between the board-level button/command logic and the LED pins, replacing per-LED free-running counters with one scheduled prescaler.

## Interface
- LED_NUM, 4, number of LEDs driven; legal range 2..16.
- CNT_MAX, 25'd24_999_999, tick counter terminal value; step period = CNT_MAX+1 cycles; must be ≥1.
- CNT_W, 25, tick counter width; must hold CNT_MAX.

- sys_clk  in  1  system clock; the single clock; all logic on posedge.
- sys_rst  in  1  asynchronous, active-high reset.
- start  in  1  command pulse; honoured only in IDLE.
- stop  in  1  command pulse; honoured in any non-IDLE state.
- mode  in  2  pattern select, sampled only in the start cycle: 00 shift-left, 01 shift-right, 10 bounce, 11 blink-all.
- busy  out  1  high in every state except IDLE.
- led_out  out  LED_NUM  LED drive, registered.
- step_done  out  1  one-cycle pulse after each pattern advance.

## Operation
- Reset values: state IDLE, busy 0, led_out 0, step_done 0, tick counter 0, latched mode 00, bounce direction left.
- IDLE: tick counter held at 0, led_out 0. start=1 and stop=0 -> LOAD.
- LOAD, one cycle: load the initial pattern and go to RUN.
  - Initial pattern: left and bounce 1 at bit 0; right 1 at bit LED_NUM-1; blink all zeros.
- RUN: tick counter counts 0..CNT_MAX and wraps to 0. tick = (cnt==CNT_MAX).
  - On a tick edge led_out advances and step_done pulses.
  - Left: rotate left, MSB wraps to bit 0.
  - Right: rotate right.
  - Bounce: shift toward the current direction. The direction flips on the step that reaches bit LED_NUM-1 or bit 0, so the lit bit never wraps.
  - Blink: led_out <= ~led_out.
- stop=1 in LOAD/RUN/PAUSE: next state IDLE, led_out 0, counter cleared, no step_done.
- Simultaneous events:
  - stop beats tick in the same cycle.
  - stop beats start.
  - start outside IDLE is ignored.
  - mode changes outside the start cycle are ignored.
- sys_rst mid-operation: all outputs return to reset values immediately, independent of the clock.

## Timing
- start high in cycle 0: LOAD in cycle 1, with busy=1 from cycle 1. RUN from cycle 2, with the initial pattern on led_out and cnt=0.
- First tick in cycle 2+CNT_MAX. led_out and step_done change in cycle 3+CNT_MAX. Every later step follows CNT_MAX+1 cycles after the previous one.
- stop high in cycle n: busy=0 and led_out=0 in cycle n+1.
- Arithmetic: counter compare is unsigned at CNT_W bits; increment width-extended; no overflow past CNT_MAX.

## Configuration
- LED_FLOW_PAUSE_EN defined:
  - Adds input pause (1 bit, level) and state PAUSE.
  - pause=1 in RUN -> PAUSE; the tick counter and led_out freeze and busy stays 1.
  - pause=0 -> RUN; counting resumes from the frozen value.
  - A tick coinciding with pause=1 is not consumed.
  - stop beats pause.
- Not defined: no pause port, no PAUSE state, RUN is never suspended.

## Structure
- Package led_flow_pkg:
  - state typedef (IDLE, LOAD, RUN, PAUSE);
  - mode constants MODE_LEFT, MODE_RIGHT, MODE_BOUNCE, MODE_BLINK.
- Sub-module tick_gen: parameterised by CNT_MAX/CNT_W; inputs en and clr; output tick. Instantiated once and driven by the FSM.
- The FSM, pattern register and direction flag stay in led_flow_ctrl.

## Test plan
All scenarios use LED_NUM=4, CNT_MAX=3.
- Reset/idle: assert sys_rst mid-cycle -> led_out 0000, busy 0, step_done 0 immediately; held with no start.
- Shift-left: start with mode=00 in cycle 0 -> led_out 0001 in cycle 2, 0010 in cycle 6, 0100 in cycle 10, 1000 in cycle 14, 0001 in cycle 18; step_done high in cycles 6, 10, 14, 18.
- Bounce: start with mode=10 -> sequence 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, one step per 4 cycles.
- Blink plus start while busy: start with mode=11 -> 0000, 1111, 0000, …; a second start with mode=00 in RUN leaves the blink sequence unchanged.
- Stop collision: stop in a tick cycle -> no pattern advance, no step_done, busy=0 and led_out=0000 next cycle; start and stop together in IDLE -> stays IDLE.
- LED_FLOW_PAUSE_EN: pause held 5 cycles in RUN -> led_out and counter frozen; the next step arrives exactly 5 cycles later than without pause.
